// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT framing constants, FSM encoding and the cfg_nfft legality check.
package fft_pkg;
  localparam int FFT_MAX_LOG2N = 10;
  localparam int FFT_MIN_LOG2N = 3;
  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;
  function automatic logic nfft_legal(input logic [4:0] cfg, input int lo = FFT_MIN_LOG2N,
                                      input int hi = FFT_MAX_LOG2N);
    return (int'(cfg) >= lo) && (int'(cfg) <= hi);
  endfunction
endpackage

// File: rtl/fft_len_latch.sv
// fft_len_latch: validates cfg_nfft, holds the frame length for the current frame and its terminal-count mask.
module fft_len_latch
  import fft_pkg::*;
#(
  parameter int MAX_LOG2N = FFT_MAX_LOG2N,
  parameter int MIN_LOG2N = FFT_MIN_LOG2N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [4:0]           cfg_nfft,
  output logic                 cfg_err,
  output logic [MAX_LOG2N-1:0] tc_mask
);
  logic [4:0] eff_log2n;
  logic       legal;
  assign legal = nfft_legal(cfg_nfft, MIN_LOG2N, MAX_LOG2N);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eff_log2n <= 5'(MAX_LOG2N);
      cfg_err   <= 1'b0;
    end else if (load) begin
      eff_log2n <= legal ? cfg_nfft : 5'(MAX_LOG2N);
      cfg_err   <= !legal;
    end
  end
  // Mask of ones below eff_log2n equals N-1 without ever forming 2^N.
  for (genvar g = 0; g < MAX_LOG2N; g++) begin : g_mask
    assign tc_mask[g] = eff_log2n > 5'(g);
  end
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: AXI-Stream framer that marks TLAST every N beats, latches N per frame and zero-pads on flush.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MAX_LOG2N   = FFT_MAX_LOG2N,
  parameter int MIN_LOG2N   = FFT_MIN_LOG2N,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             cfg_nfft,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [MAX_LOG2N-1:0]   sample_idx,
  output logic [FRAME_CNT_W-1:0] frame_idx,
  output logic                   frame_done,
  output logic                   frame_padded,
  output logic                   cfg_err
);
  state_t               state, state_nx;
  logic [MAX_LOG2N-1:0] tc_mask;
  logic                 hs, last_hs, pad_seen;
  fft_len_latch #(.MAX_LOG2N(MAX_LOG2N), .MIN_LOG2N(MIN_LOG2N)) u_len (
    .clk     (clk),
    .rst     (rst),
    .load    (state == IDLE),
    .cfg_nfft(cfg_nfft),
    .cfg_err (cfg_err),
    .tc_mask (tc_mask)
  );
  assign hs      = m_axis_tvalid & m_axis_tready;
  assign last_hs = hs & m_axis_tlast;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sample_idx   <= '0;
      frame_idx    <= '0;
      frame_done   <= 1'b0;
      frame_padded <= 1'b0;
      pad_seen     <= 1'b0;
    end else begin
      state        <= state_nx;
      if (hs) sample_idx <= m_axis_tlast ? '0 : sample_idx + MAX_LOG2N'(1);
      if (last_hs) frame_idx <= frame_idx + FRAME_CNT_W'(1);
      frame_done   <= last_hs;
      frame_padded <= last_hs & pad_seen;
      pad_seen     <= last_hs ? 1'b0 : pad_seen | (state == RUN && flush);
    end
  end
  // A flush coinciding with the tlast handshake is dropped: the frame is already complete.
  always_comb begin
    state_nx = last_hs                  ? IDLE :
               (state == IDLE && hs)    ? RUN  :
               (state == RUN  && flush) ? PAD  : state;
  end
  always_comb begin
    m_axis_tdata  = (state == PAD) ? '0 : s_axis_tdata;
    m_axis_tvalid = (state == PAD) | s_axis_tvalid;
    s_axis_tready = (state != PAD) & m_axis_tready;
    m_axis_tlast  = m_axis_tvalid & (sample_idx == tc_mask);
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized frame stimulus with a scoreboard of expected beats and frame_done records.
module tb_fft_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  cfg_nfft = 5'd10;
  logic        flush = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [9:0]  sample_idx;
  logic [15:0] frame_idx;
  logic        frame_done, frame_padded, cfg_err;

  fft_frame_ctrl #(.DATA_W(32), .MAX_LOG2N(10), .MIN_LOG2N(3), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_nfft(cfg_nfft), .flush(flush),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .sample_idx(sample_idx), .frame_idx(frame_idx),
    .frame_done(frame_done), .frame_padded(frame_padded), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] data; logic last; int idx;} beat_t;
  typedef struct {logic padded; logic [15:0] fidx;} done_t;
  beat_t       exp_q[$];
  done_t       done_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] fcount = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_len(input logic [4:0] c);
    return (c >= 3 && c <= 10) ? (1 << c) : 1024;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_sample_idx", 64'(sample_idx), 64'd0);
    chk("rst_frame_idx", 64'(frame_idx), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_frame_padded", 64'(frame_padded), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
  endtask

  // Monitor: samples mid-cycle, after the driver's negedge updates have settled.
  logic        prev_stall = 1'b0, exp_done = 1'b0, pl;
  logic [31:0] pd;
  logic [9:0]  pi;
  beat_t       b;
  done_t       d;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_data", 64'(m_axis_tdata), 64'(pd));
        chk("stall_last", 64'(m_axis_tlast), 64'(pl));
        chk("stall_idx", 64'(sample_idx), 64'(pi));
      end
      chk("frame_done", 64'(frame_done), 64'(exp_done));
      if (frame_done) begin
        if (done_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame_done: got 1 expected no pending frame at %0t", $time);
        end else begin
          d = done_q.pop_front();
          chk("frame_padded", 64'(frame_padded), 64'(d.padded));
          chk("frame_idx", 64'(frame_idx), 64'(d.fidx));
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got data 0x%0h expected no beat at %0t", m_axis_tdata, $time);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", 64'(m_axis_tdata), 64'(b.data));
          chk("beat_last", 64'(m_axis_tlast), 64'(b.last));
          chk("beat_idx", 64'(sample_idx), 64'(b.idx));
        end
      end
      exp_done   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
      prev_stall = m_axis_tvalid & !m_axis_tready;
      pd = m_axis_tdata; pl = m_axis_tlast; pi = sample_idx;
    end
  end

  // Entered and left just after a negedge. flush_at: beat index flushed with its own handshake.
  task automatic run_frame(input logic [4:0] cfg, input int flush_at, input bit stall,
                           input int chg_at, input logic [4:0] cfg2, input int rst_at);
    int len, r, sent, seen, cyc;
    logic [31:0] w[];
    len = model_len(cfg);
    r = (flush_at >= 1 && flush_at < len - 1) ? flush_at + 1 : len;
    cfg_nfft = cfg;
    s_axis_tvalid = 1'b0;
    flush = 1'($urandom_range(0, 1));
    m_axis_tready = 1'($urandom_range(0, 1));
    @(negedge clk);
    flush = 1'b0;
    chk("cfg_err", 64'(cfg_err), 64'(!(cfg >= 3 && cfg <= 10)));
    w = new[len];
    for (int i = 0; i < len; i++) begin
      w[i] = $urandom;
      exp_q.push_back('{data: (i < r) ? w[i] : 32'd0, last: (i == len - 1), idx: i});
    end
    if (rst_at < 0) begin
      fcount = fcount + 16'd1;
      done_q.push_back('{padded: (r < len), fidx: fcount});
    end
    sent = 0; seen = 0; cyc = 0;
    while (seen < len) begin
      if (seen == rst_at) begin
        rst = 1'b1; s_axis_tvalid = 1'b0; flush = 1'b0;
        exp_q.delete(); fcount = '0;
        #1;
        chk_reset_vals();
        #2;
        rst = 1'b0;
        break;
      end
      m_axis_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sent < r) begin
        if (!s_axis_tvalid) s_axis_tvalid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_axis_tdata = w[sent];
      end else begin
        s_axis_tvalid = 1'($urandom_range(0, 1));
        s_axis_tdata = $urandom;
      end
      flush = (sent == flush_at) ? 1'b1 : (sent >= r && r < len) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (sent == flush_at) begin
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
      end
      if (sent == chg_at) cfg_nfft = cfg2;
      #2;
      if (s_axis_tvalid && s_axis_tready) sent++;
      if (m_axis_tvalid && m_axis_tready) seen++;
      if (++cyc > 20000) begin
        tests++; fails++;
        $display("FAIL frame_timeout: got %0d beats expected %0d", seen, len);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
      if (seen < len) @(negedge clk);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    int c, f;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) run_frame(5'd10, -1, 1'b0, -1, 5'd0, -1);
    repeat (4) run_frame(5'd7, -1, 1'b1, -1, 5'd0, -1);
    run_frame(5'd9, -1, 1'b1, 100, 5'd8, -1);
    run_frame(5'd8, -1, 1'b0, -1, 5'd0, -1);
    run_frame(5'd8, 40, 1'b0, -1, 5'd0, -1);
    run_frame(5'd8, 40, 1'b1, -1, 5'd0, -1);
    run_frame(5'd2, -1, 1'b0, -1, 5'd0, -1);
    run_frame(5'd12, -1, 1'b1, -1, 5'd0, -1);
    run_frame(5'd7, -1, 1'b0, -1, 5'd0, -1);
    run_frame(5'd10, -1, 1'b0, -1, 5'd0, 300);
    run_frame(5'd7, -1, 1'b1, -1, 5'd0, -1);
    run_frame(5'd3, 7, 1'b1, -1, 5'd0, -1);
    repeat (6) begin
      c = $urandom_range(3, 6);
      f = $urandom_range(0, 1) ? int'($urandom_range(1, (1 << c) - 1)) : -1;
      run_frame(5'(c), f, 1'b1, -1, 5'd0, -1);
    end
    repeat (3) @(negedge clk);
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("frames_left", 64'(done_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
